// File: rtl/spio_aer2spinn_mapper_fifo.sv
// spio_aer2spinn_mapper_fifo: AER event mapper with FWFT packet FIFO toward a SpiNNaker link.
// Optional macro SPIO_AER_DROP_EN: acknowledge and discard events while the FIFO is full.
module spio_aer2spinn_mapper_fifo #(
    parameter int AER_BITS       = 16,
    parameter int COORD_BITS     = 7,
    parameter int FIFO_ADDR_BITS = 2,
    parameter int PKT_BITS       = 72
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                vmode,
    input  logic [1:0]                vshift,
    input  logic [31-AER_BITS:0]      vkey,
    input  logic [AER_BITS-1:0]       iaer_data,
    input  logic                      iaer_req,
    output logic                      iaer_ack,
    output logic [PKT_BITS-1:0]       ipkt_data,
    output logic                      ipkt_vld,
    input  logic                      ipkt_rdy,
    output logic [31:0]               evt_count,
    output logic [FIFO_ADDR_BITS:0]   fifo_level
`ifdef SPIO_AER_DROP_EN
   ,output logic [15:0]               drop_count
`endif
);
    localparam int C     = COORD_BITS;
    localparam int DEPTH = 2 ** FIFO_ADDR_BITS;
    localparam int LW    = FIFO_ADDR_BITS + 1;

    typedef enum logic {IDLE, WREL} state_t;
    state_t state, state_nxt;

    logic [1:0]                req_sync;
    logic                      req_s, full, push, pop, drop;
    logic [PKT_BITS-1:0]       mem [DEPTH];
    logic [FIFO_ADDR_BITS-1:0] wr_ptr, rd_ptr;
    logic [C-1:0]              x_in, y_in, x_m, y_m;
    logic [2*C-1:0]            xy;
    logic [AER_BITS-1:0]       retina, coords;
    logic [PKT_BITS-2:0]       body;

    assign req_s  = req_sync[1];
    assign x_in   = iaer_data[C:1];
    assign y_in   = iaer_data[2*C:C+1];
    // Rotation: (2^C-1)-v at C bits is just the bitwise complement.
    assign x_m    = vmode[0] ? x_in : ~y_in;
    assign y_m    = vmode[0] ? y_in : ~x_in;
    assign xy     = ((2*C)'(y_m >> vshift) << (C - int'(vshift))) | (2*C)'(x_m >> vshift);
    assign retina = ((iaer_data >> (2*C+1)) << (2*C+1)) | (AER_BITS'(iaer_data[0]) << (2*C)) | AER_BITS'(xy);
    assign coords = vmode[1] ? iaer_data : retina;
    assign body   = (PKT_BITS-1)'({vkey, coords, 7'd0});

    assign full      = fifo_level == LW'(DEPTH);
    assign ipkt_vld  = fifo_level != '0;
    assign pop       = ipkt_vld && ipkt_rdy;
    assign ipkt_data = ipkt_vld ? mem[rd_ptr] : '0;
    assign iaer_ack  = state == IDLE;

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        drop      = 1'b0;
        if (state == IDLE && !req_s) begin
            push = !full;
`ifdef SPIO_AER_DROP_EN
            drop = full;
`endif
            state_nxt = (push || drop) ? WREL : IDLE;
        end else if (state == WREL && req_s) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            req_sync   <= 2'b11;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            evt_count  <= '0;
`ifdef SPIO_AER_DROP_EN
            drop_count <= '0;
`endif
        end else begin
            state      <= state_nxt;
            req_sync   <= {req_sync[0], iaer_req};
            wr_ptr     <= wr_ptr + FIFO_ADDR_BITS'(push);
            rd_ptr     <= rd_ptr + FIFO_ADDR_BITS'(pop);
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
            evt_count  <= evt_count + 32'(push);
`ifdef SPIO_AER_DROP_EN
            drop_count <= drop_count + 16'(drop && drop_count != 16'hFFFF);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {body, ~^body};
    end
endmodule

// File: tb/tb_spio_aer2spinn_mapper_fifo.sv
// tb_spio_aer2spinn_mapper_fifo: vector table, corner sequences and randomized events
// checked against a scoreboard of packets computed from the mapping rules.
module tb_spio_aer2spinn_mapper_fifo;
    logic        clk = 0;
    logic        rst = 0;
    logic [1:0]  vmode = 0;
    logic [1:0]  vshift = 0;
    logic [15:0] vkey = 16'h1234;
    logic [15:0] iaer_data = 0;
    logic        iaer_req = 1;
    logic        iaer_ack;
    logic [71:0] ipkt_data;
    logic        ipkt_vld;
    logic        ipkt_rdy;
    logic [31:0] evt_count;
    logic [2:0]  fifo_level;
`ifdef SPIO_AER_DROP_EN
    logic [15:0] drop_count;
`endif
    logic        rnd_mode = 0, rnd_bit = 0, rdy_set = 1;

    assign ipkt_rdy = rnd_mode ? rnd_bit : rdy_set;

    spio_aer2spinn_mapper_fifo dut (
        .clk(clk), .rst(rst), .vmode(vmode), .vshift(vshift), .vkey(vkey),
        .iaer_data(iaer_data), .iaer_req(iaer_req), .iaer_ack(iaer_ack),
        .ipkt_data(ipkt_data), .ipkt_vld(ipkt_vld), .ipkt_rdy(ipkt_rdy),
        .evt_count(evt_count), .fifo_level(fifo_level)
`ifdef SPIO_AER_DROP_EN
       ,.drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1 rnd_bit = ($urandom_range(0, 3) != 0);
    end

    int n_vec = 0, n_err = 0, exp_evt = 0;
    logic [71:0] q[$];

    typedef struct {
        logic [15:0] data;
        logic [1:0]  mode;
        logic [1:0]  shift;
        logic [71:0] pkt;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] model(input logic [15:0] d, input logic [1:0] m,
                                          input logic [1:0] s, input logic [15:0] k);
        int x, y, xp, yp, sh;
        logic [15:0] c;
        logic [71:0] p;
        x  = int'(d >> 1) % 128;
        y  = int'(d >> 8) % 128;
        sh = int'(s);
        xp = (m == 0) ? 127 - y : x;
        yp = (m == 0) ? 127 - x : y;
        c  = (m >= 2) ? d : 16'(int'(d & 16'h8000) | (int'(d[0]) << 14) | ((yp >> sh) << (7 - sh)) | (xp >> sh));
        p  = {32'd0, k, c, 8'd0};
        p[0] = ($countones(p) % 2 == 0);
        return p;
    endfunction

    logic        stalled = 0;
    logic [71:0] held;
    always @(negedge clk) begin
        if (!rst) begin
            stalled = 0;
        end else begin
            if (stalled && ipkt_vld) chk("hold_stable", ipkt_data, held);
            if (ipkt_vld && ipkt_rdy) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_pkt: got %h expected none", ipkt_data);
                end else begin
                    chk("pkt_data", ipkt_data, q.pop_front());
                end
            end
            stalled = ipkt_vld && !ipkt_rdy;
            held = ipkt_data;
        end
    end

    task automatic wait_ack(input logic lvl, input string name);
        int n = 0;
        while (iaer_ack !== lvl && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(name, 72'(n), 72'd4);
    endtask

    task automatic send(input logic [15:0] d, input logic [71:0] e, input bit keep);
        iaer_data = d;
        iaer_req = 0;
        wait_ack(1'b0, "ack_fall_edges");
        if (keep) begin
            q.push_back(e);
            exp_evt++;
        end
        @(posedge clk); #1 iaer_req = 1;
        wait_ack(1'b1, "ack_rise_edges");
        @(posedge clk); #1;
    endtask

    task automatic drain();
        rdy_set = 1;
        repeat (12) @(posedge clk);
        #1 chk("queue_drained", 72'(q.size()), 72'd0);
    endtask

    initial begin
        tbl[0] = '{16'h0000, 2'd0, 2'd0, 72'h0000000012343FFF00};
        tbl[1] = '{16'h0080, 2'd1, 2'd1, 72'h000000001234002001};
        tbl[2] = '{16'hA5C3, 2'd2, 2'd0, 72'h000000001234A5C300};
        tbl[3] = '{16'h0001, 2'd0, 2'd0, 72'h0000000012347FFF01};
        tbl[4] = '{16'hFFFF, 2'd1, 2'd3, 72'h000000001234C0FF00};
        tbl[5] = '{16'h0102, 2'd0, 2'd2, 72'h00000000123403FF00};

        @(negedge clk);
        chk("reset_ack", 72'(iaer_ack), 72'd1);
        chk("reset_vld", 72'(ipkt_vld), 72'd0);
        chk("reset_data", ipkt_data, 72'd0);
        chk("reset_level", 72'(fifo_level), 72'd0);
        chk("reset_evt", 72'(evt_count), 72'd0);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            vmode = tbl[i].mode;
            vshift = tbl[i].shift;
            send(tbl[i].data, tbl[i].pkt, 1);
            if (i == 0) chk("evt_after_first", 72'(evt_count), 72'd1);
        end
        drain();

        // Output held stable under backpressure; config changes after capture ignored
        rdy_set = 0;
        vmode = 2;
        iaer_data = 16'hA5C3;
        iaer_req = 0;
        wait_ack(1'b0, "ack_fall_edges");
        q.push_back(72'h000000001234A5C300);
        exp_evt++;
        vkey = 16'hFFFF;
        vmode = 0;
        vshift = 3;
        @(posedge clk); #1 iaer_req = 1;
        repeat (10) @(negedge clk);
        chk("hold_data_10", ipkt_data, 72'h000000001234A5C300);
        vkey = 16'h1234;
        drain();

`ifndef SPIO_AER_DROP_EN
        // Full FIFO stalls the fifth handshake until a slot frees, with no output gaps
        rdy_set = 0;
        vmode = 1;
        vshift = 0;
        for (int i = 0; i < 4; i++) send(16'(i * 2 + 16'h0100), model(16'(i * 2 + 16'h0100), 1, 0, vkey), 1);
        chk("level_full", 72'(fifo_level), 72'd4);
        iaer_data = 16'h7E55;
        iaer_req = 0;
        repeat (8) @(negedge clk);
        chk("ack_held_full", 72'(iaer_ack), 72'd1);
        q.push_back(model(16'h7E55, 1, 0, vkey));
        @(posedge clk); #1 rdy_set = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_gap_vld", 72'(ipkt_vld), 72'd1);
        end
        @(negedge clk);
        chk("empty_after_5", 72'(ipkt_vld), 72'd0);
        chk("ack_fifth", 72'(iaer_ack), 72'd0);
        exp_evt++;
        @(posedge clk); #1 iaer_req = 1;
        wait_ack(1'b1, "ack_rise_edges");
        chk("evt_count_full", 72'(evt_count), 72'(exp_evt));
`else
        // Drop mode: full FIFO acknowledges and discards
        rdy_set = 0;
        vmode = 1;
        vshift = 0;
        for (int i = 0; i < 6; i++) send(16'(i * 2 + 16'h0100), model(16'(i * 2 + 16'h0100), 1, 0, vkey), i < 4);
        chk("drop_count", 72'(drop_count), 72'd2);
        chk("evt_count_drop", 72'(evt_count), 72'(exp_evt));
        chk("level_drop", 72'(fifo_level), 72'd4);
`endif
        drain();

        // Reset in the middle of a handshake with two entries buffered
        rdy_set = 0;
        vmode = 0;
        vshift = 1;
        send(16'h1111, model(16'h1111, 0, 1, vkey), 1);
        send(16'h2222, model(16'h2222, 0, 1, vkey), 1);
        iaer_data = 16'h3333;
        iaer_req = 0;
        wait_ack(1'b0, "ack_fall_edges");
        #2 rst = 0;
        #1;
        chk("rst_ack", 72'(iaer_ack), 72'd1);
        chk("rst_vld", 72'(ipkt_vld), 72'd0);
        chk("rst_level", 72'(fifo_level), 72'd0);
        chk("rst_evt", 72'(evt_count), 72'd0);
        q.delete();
        exp_evt = 0;
        @(posedge clk); #1 rst = 1;
        wait_ack(1'b0, "ack_after_reset");
        q.push_back(model(16'h3333, 0, 1, vkey));
        exp_evt++;
        @(posedge clk); #1 iaer_req = 1;
        wait_ack(1'b1, "ack_rise_edges");
        chk("evt_after_reset", 72'(evt_count), 72'd1);
        drain();

        // Randomized events against the reference model
`ifndef SPIO_AER_DROP_EN
        rnd_mode = 1;
`endif
        for (int i = 0; i < 40; i++) begin
            logic [15:0] d;
            d = 16'($urandom);
            vmode = 2'($urandom_range(0, 3));
            vshift = 2'($urandom_range(0, 3));
            vkey = 16'($urandom);
            send(d, model(d, vmode, vshift, vkey), 1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        rnd_mode = 0;
        drain();
        chk("evt_count_final", 72'(evt_count), 72'(exp_evt));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
